slow_dn_cnt: RTL



---
 rtl/slow_cnt_pkg.sv | 18 +
 rtl/slow_dn_cnt_tick_gen.sv | 33 +++
 rtl/slow_dn_cnt.sv | 52 +++++
 3 files changed

// File: rtl/slow_cnt_pkg.sv
// Shared constants and helpers for the slow up/down counter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package slow_cnt_pkg;

  // Board system clock; a prescaler of CLK_HZ gives one tick per second.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Prescaler counter width: clog2(div), never less than one bit so that
  // DIV = 1 and DIV = 2 still produce a legal vector.
  function automatic int unsigned presc_width(input int unsigned div);
    if (div <= 2) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage

// File: rtl/slow_dn_cnt_tick_gen.sv
// Clock-enable tick generator: one-cycle tick every DIV clk cycles.
// Latency: tick is combinational from the phase counter, high when p == DIV-1.
// Backpressure: none; free-running, restart forces the phase back to zero.
module tick_gen
  import slow_cnt_pkg::*;
#(
  parameter int unsigned DIV = CLK_HZ
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     PW    = presc_width(DIV);
  localparam logic [PW-1:0]   P_MAX = PW'(DIV - 1);

  logic [PW-1:0] p;

  // Phase counter runs 0..DIV-1; restart realigns it so the next tick is DIV cycles away.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p <= '0;
    end else if (restart || tick) begin
      p <= '0;
    end else begin
      p <= p + 1'b1;
    end
  end

  assign tick = (p == P_MAX);

endmodule

// File: rtl/slow_dn_cnt.sv
// Loadable down-counter stepped by a prescaled tick, with wrap flag and complement output.
// Latency: Q updates on the tick edge; tc is high the cycle after the 0 -> all-ones wrap.
// Backpressure: none; en freezes Q while the prescaler keeps its phase.
module slow_dn_cnt
  import slow_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DIV   = CLK_HZ
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             zero,
  output logic             tc
);

  logic tick;

  // A load restarts the prescaler so the first decrement lands DIV cycles after it.
  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .clr    (clr),
    .restart(ld),
    .tick   (tick)
  );

  // Count register and wrap pulse: load beats tick, tc only lasts one cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q  <= '0;
      tc <= 1'b0;
    end else if (ld) begin
      Q  <= D;
      tc <= 1'b0;
    end else if (tick && en) begin
      Q  <= Q - 1'b1;
      tc <= (Q == '0);
    end else begin
      tc <= 1'b0;
    end
  end

  assign Qb   = ~Q;
  assign zero = (Q == '0);

endmodule
